mem_responder: RTL and testbench

MEM_RESPONDER -- requirements
Module: mem_responder

---
 rtl/mem_responder.sv | 127 ++++++++++++
 tb/tb_mem_responder.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_responder.sv
// Responder end of the cache memory bus: one whole-line transaction at a time,
// I-cache reads and D-cache reads/writes arbitrated round-robin on ties.
module mem_responder #(
    parameter int MBLEN     = 128,
    parameter int PHY_LEN   = 20,
    parameter int MEM_LINES = 256,
    parameter int MEM_LAT   = 4
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic               ic_req_valid_i,
    input  logic [PHY_LEN-1:0] ic_req_addr_i,
    output logic               ic_req_ready_o,
    output logic               ic_rsp_valid_o,
    output logic [MBLEN-1:0]   ic_rsp_data_o,
    input  logic               dc_req_valid_i,
    input  logic               dc_req_we_i,
    input  logic [PHY_LEN-1:0] dc_req_addr_i,
    input  logic [MBLEN-1:0]   dc_req_wdata_i,
    output logic               dc_req_ready_o,
    output logic               dc_rsp_valid_o,
    output logic [MBLEN-1:0]   dc_rsp_data_o
);
    localparam int IDXW = $clog2(MEM_LINES);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    logic [1:0]       state;
    logic [3:0]       cnt;
    logic             last_dc;
    logic             port_dc;
    logic             we_q;
    logic [IDXW-1:0]  idx_q;
    logic [MBLEN-1:0] wdata_q;
    logic [MBLEN-1:0] mem [MEM_LINES];

    logic             hs;
    logic             commit;
    logic             cur_dc;
    logic             cur_we;
    logic [IDXW-1:0]  cur_idx;
    logic [MBLEN-1:0] cur_wdata;
    logic [MBLEN-1:0] rsp_next;
    logic             unused_addr;

    // Only the line index bits select storage; the rest alias.
    assign unused_addr = ^{ic_req_addr_i, dc_req_addr_i};

    // On a tie the port not served last wins; last_dc resets to 1 so I wins first.
    assign ic_req_ready_o = rst_ni & (state == S_IDLE) & ic_req_valid_i
                          & (~dc_req_valid_i | last_dc);
    assign dc_req_ready_o = rst_ni & (state == S_IDLE) & dc_req_valid_i
                          & (~ic_req_valid_i | ~last_dc);
    assign hs = ic_req_ready_o | dc_req_ready_o;

    // Latency is counted from the handshake edge: the access happens at the
    // edge where the counter reaches zero, which for MEM_LAT=1 is the handshake itself.
    assign commit = (hs & (MEM_LAT == 1)) | ((state == S_BUSY) & (cnt == 4'd1));

    always_comb begin
        cur_dc    = port_dc;
        cur_we    = we_q;
        cur_idx   = idx_q;
        cur_wdata = wdata_q;
        if (hs) begin
            cur_dc    = dc_req_ready_o;
            cur_we    = dc_req_ready_o & dc_req_we_i;
            cur_idx   = dc_req_ready_o ? dc_req_addr_i[4 +: IDXW] : ic_req_addr_i[4 +: IDXW];
            cur_wdata = dc_req_wdata_i;
        end
    end

    assign rsp_next = cur_we ? cur_wdata : mem[cur_idx];

    always_ff @(posedge clk_i) begin
        if (commit && cur_we)
            mem[cur_idx] <= cur_wdata;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state          <= S_IDLE;
            cnt            <= 4'd0;
            last_dc        <= 1'b1;
            port_dc        <= 1'b0;
            we_q           <= 1'b0;
            idx_q          <= '0;
            wdata_q        <= '0;
            ic_rsp_valid_o <= 1'b0;
            dc_rsp_valid_o <= 1'b0;
            ic_rsp_data_o  <= '0;
            dc_rsp_data_o  <= '0;
        end else begin
            ic_rsp_valid_o <= 1'b0;
            dc_rsp_valid_o <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (hs) begin
                        port_dc <= cur_dc;
                        we_q    <= cur_we;
                        idx_q   <= cur_idx;
                        wdata_q <= cur_wdata;
                        last_dc <= cur_dc;
                        cnt     <= 4'(MEM_LAT - 1);
                        state   <= (MEM_LAT == 1) ? S_RESP : S_BUSY;
                    end
                end
                S_BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1)
                        state <= S_RESP;
                end
                default: state <= S_IDLE;
            endcase
            if (commit) begin
                if (cur_dc) begin
                    dc_rsp_valid_o <= 1'b1;
                    dc_rsp_data_o  <= rsp_next;
                end else begin
                    ic_rsp_valid_o <= 1'b1;
                    ic_rsp_data_o  <= rsp_next;
                end
            end
        end
    end
endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: directed vector table, hand-written reset/arbitration
// sequences, and a randomized run against a transaction-timeline reference model.
module tb_mem_responder;
    localparam int L = 4;

    typedef struct {
        bit           dc;
        bit           we;
        logic [19:0]  addr;
        logic [127:0] wdata;
        logic [127:0] want;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         ic_valid, ic_ready, ic_rsp_valid;
    logic [19:0]  ic_addr;
    logic [127:0] ic_rsp_data;
    logic         dc_valid, dc_we, dc_ready, dc_rsp_valid;
    logic [19:0]  dc_addr;
    logic [127:0] dc_wdata, dc_rsp_data;

    logic         f_ic_valid, f_ic_ready, f_ic_rsp_valid;
    logic [19:0]  f_ic_addr;
    logic [127:0] f_ic_rsp_data;
    logic         f_dc_valid, f_dc_we, f_dc_ready, f_dc_rsp_valid;
    logic [19:0]  f_dc_addr;
    logic [127:0] f_dc_wdata, f_dc_rsp_data;

    int nerr = 0;
    int nchk = 0;

    always #5 clk = ~clk;

    mem_responder dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ic_req_valid_i(ic_valid), .ic_req_addr_i(ic_addr), .ic_req_ready_o(ic_ready),
        .ic_rsp_valid_o(ic_rsp_valid), .ic_rsp_data_o(ic_rsp_data),
        .dc_req_valid_i(dc_valid), .dc_req_we_i(dc_we), .dc_req_addr_i(dc_addr),
        .dc_req_wdata_i(dc_wdata), .dc_req_ready_o(dc_ready),
        .dc_rsp_valid_o(dc_rsp_valid), .dc_rsp_data_o(dc_rsp_data)
    );

    mem_responder #(.MEM_LAT(1)) dut_fast (
        .clk_i(clk), .rst_ni(rst_n),
        .ic_req_valid_i(f_ic_valid), .ic_req_addr_i(f_ic_addr), .ic_req_ready_o(f_ic_ready),
        .ic_rsp_valid_o(f_ic_rsp_valid), .ic_rsp_data_o(f_ic_rsp_data),
        .dc_req_valid_i(f_dc_valid), .dc_req_we_i(f_dc_we), .dc_req_addr_i(f_dc_addr),
        .dc_req_wdata_i(f_dc_wdata), .dc_req_ready_o(f_dc_ready),
        .dc_rsp_valid_o(f_dc_rsp_valid), .dc_rsp_data_o(f_dc_rsp_data)
    );

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        nchk++;
        if (act !== want) begin
            nerr++;
            $display("FAIL %s: got %h want %h", nm, act, want);
        end
    endtask

    // Release happens #1 after a rising edge, so the caller continues in cycle 0.
    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        ic_valid = 1'b0; dc_valid = 1'b0; f_ic_valid = 1'b0; f_dc_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // One transaction on the main instance, DUT assumed idle; ends at the start of T+L+1.
    task automatic do_txn(input bit dc, input bit we, input logic [19:0] addr,
                          input logic [127:0] wdata, input logic [127:0] want, input string nm);
        if (dc) begin
            dc_valid = 1'b1; dc_we = we; dc_addr = addr; dc_wdata = wdata;
        end else begin
            ic_valid = 1'b1; ic_addr = addr;
        end
        @(negedge clk);
        chk({nm, " ready"}, dc ? dc_ready : ic_ready, 1);
        @(posedge clk); #1;
        ic_valid = 1'b0; dc_valid = 1'b0;
        for (int k = 1; k <= L; k++) begin
            @(negedge clk);
            chk({nm, " rsp_valid"}, dc ? dc_rsp_valid : ic_rsp_valid, (k == L));
            chk({nm, " other_valid"}, dc ? ic_rsp_valid : dc_rsp_valid, 0);
            if (k == L) chk({nm, " data"}, dc ? dc_rsp_data : ic_rsp_data, want);
        end
        @(posedge clk); #1;
    endtask

    vec_t vt[8];

    // Reference model state for the randomized phase (lines 0..7 only).
    logic [127:0] mm[8];
    bit           known[8];
    int           free_at, rsp_cyc;
    bit           m_last_dc, rsp_dc, rsp_known, gi, gd;
    logic [127:0] rsp_val, e_ic, e_dc;
    bit           k_ic, k_dc;

    initial begin
        logic [19:0] a;
        logic [2:0]  line;

        vt[0] = '{1, 1, 20'h00040, {16{8'hA5}}, {16{8'hA5}}};
        vt[1] = '{0, 0, 20'h00040, '0,          {16{8'hA5}}};
        vt[2] = '{1, 1, 20'h00043, {16{8'hC3}}, {16{8'hC3}}};
        vt[3] = '{1, 0, 20'h01040, '0,          {16{8'hC3}}};
        vt[4] = '{1, 1, 20'h00070, {16{8'h11}}, {16{8'h11}}};
        vt[5] = '{0, 0, 20'hFF07C, '0,          {16{8'h11}}};
        vt[6] = '{1, 1, 20'h00FF0, {4{32'hDEADBEEF}}, {4{32'hDEADBEEF}}};
        vt[7] = '{0, 0, 20'h10FF5, '0,          {4{32'hDEADBEEF}}};

        rst_n = 1'b0;
        ic_valid = 1'b1; ic_addr = '0;
        dc_valid = 1'b1; dc_we = 1'b0; dc_addr = '0; dc_wdata = '0;
        f_ic_valid = 1'b1; f_ic_addr = '0;
        f_dc_valid = 1'b0; f_dc_we = 1'b0; f_dc_addr = '0; f_dc_wdata = '0;

        // Outputs held at reset values even with requests pending.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset ic_ready", ic_ready, 0);
        chk("reset dc_ready", dc_ready, 0);
        chk("reset rsp_valid", {ic_rsp_valid, dc_rsp_valid}, 0);
        chk("reset ic_data", ic_rsp_data, 0);
        chk("reset dc_data", dc_rsp_data, 0);
        chk("reset fast ic_ready", f_ic_ready, 0);
        ic_valid = 1'b0; dc_valid = 1'b0; f_ic_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;

        // MEM_LAT=1 build: write ack next cycle, then a held I read.
        f_dc_valid = 1'b1; f_dc_we = 1'b1; f_dc_addr = 20'h00000; f_dc_wdata = {16{8'h33}};
        @(negedge clk);
        chk("lat1 dc_ready first edge", f_dc_ready, 1);
        @(posedge clk); #1; f_dc_valid = 1'b0;
        @(negedge clk);
        chk("lat1 dc_rsp_valid T+1", f_dc_rsp_valid, 1);
        chk("lat1 dc_rsp_data", f_dc_rsp_data, {16{8'h33}});
        @(posedge clk); #1;
        f_ic_valid = 1'b1; f_ic_addr = 20'h00008;
        @(negedge clk);
        chk("lat1 ic_ready T", f_ic_ready, 1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1 ic_rsp_valid T+1", f_ic_rsp_valid, 1);
        chk("lat1 ic_ready T+1", f_ic_ready, 0);
        chk("lat1 ic_rsp_data", f_ic_rsp_data, {16{8'h33}});
        @(posedge clk); #1;
        @(negedge clk);
        chk("lat1 ic_ready T+2", f_ic_ready, 1);
        chk("lat1 ic_rsp_valid T+2", f_ic_rsp_valid, 0);
        @(posedge clk); #1; f_ic_valid = 1'b0;

        for (int i = 0; i < 8; i++)
            do_txn(vt[i].dc, vt[i].we, vt[i].addr, vt[i].wdata, vt[i].want, $sformatf("vec%0d", i));

        // Both ports valid from reset: I at 0, D at 5, I at 10, D at 15.
        do_reset();
        ic_valid = 1'b1; ic_addr = 20'h00040;
        dc_valid = 1'b1; dc_we = 1'b0; dc_addr = 20'h00070;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk($sformatf("alt ic_ready c%0d", c), ic_ready, (c % 10 == 0));
            chk($sformatf("alt dc_ready c%0d", c), dc_ready, (c % 10 == 5));
            chk($sformatf("alt ic_rsp c%0d", c), ic_rsp_valid, (c % 10 == 4));
            chk($sformatf("alt dc_rsp c%0d", c), dc_rsp_valid, (c % 10 == 9));
            if (c % 10 == 4) chk("alt ic_data", ic_rsp_data, {16{8'hC3}});
            if (c % 10 == 9) chk("alt dc_data", dc_rsp_data, {16{8'h11}});
            @(posedge clk); #1;
        end
        ic_valid = 1'b0; dc_valid = 1'b0;

        // Reset during BUSY of a write to line 7: no response, no commit.
        dc_valid = 1'b1; dc_we = 1'b1; dc_addr = 20'h00070; dc_wdata = {16{8'hEE}};
        @(negedge clk);
        chk("abort dc_ready", dc_ready, 1);
        @(posedge clk); #1; dc_valid = 1'b0;
        @(negedge clk);
        chk("abort busy no rsp", dc_rsp_valid, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("abort no dc_rsp", dc_rsp_valid, 0);
            chk("abort no ic_rsp", ic_rsp_valid, 0);
            chk("abort dc_data cleared", dc_rsp_data, 0);
            @(posedge clk); #1;
        end
        rst_n = 1'b1;
        do_txn(1, 0, 20'h00070, '0, {16{8'h11}}, "abort line7 kept");

        // Randomized traffic against the timeline model.
        do_reset();
        free_at = 0; rsp_cyc = -1; m_last_dc = 1'b1; gi = 1'b0; gd = 1'b0;
        e_ic = '0; e_dc = '0; k_ic = 1'b1; k_dc = 1'b1;
        rsp_dc = 1'b0; rsp_val = '0; rsp_known = 1'b0;
        for (int i = 0; i < 8; i++) begin known[i] = 1'b0; mm[i] = '0; end
        for (int c = 0; c < 400; c++) begin
            if (gi) ic_valid = 1'b0;
            if (gd) dc_valid = 1'b0;
            if (!ic_valid && $urandom_range(0, 2) != 0) begin
                a = 20'($urandom);
                a[11:4] = {5'd0, 3'($urandom_range(0, 7))};
                ic_valid = 1'b1; ic_addr = a;
            end
            if (!dc_valid && $urandom_range(0, 2) != 0) begin
                a = 20'($urandom);
                a[11:4] = {5'd0, 3'($urandom_range(0, 7))};
                dc_valid = 1'b1; dc_addr = a; dc_we = 1'($urandom);
                dc_wdata = {$urandom, $urandom, $urandom, $urandom};
            end
            @(negedge clk);
            if (c == rsp_cyc) begin
                if (rsp_dc) begin e_dc = rsp_val; k_dc = rsp_known; end
                else begin e_ic = rsp_val; k_ic = rsp_known; end
            end
            gi = 1'b0; gd = 1'b0;
            if (c >= free_at && (ic_valid || dc_valid)) begin
                if (dc_valid && !(ic_valid && m_last_dc)) gd = 1'b1;
                else gi = 1'b1;
            end
            chk($sformatf("rnd ic_ready c%0d", c), ic_ready, gi);
            chk($sformatf("rnd dc_ready c%0d", c), dc_ready, gd);
            chk($sformatf("rnd ic_rsp c%0d", c), ic_rsp_valid, (c == rsp_cyc && !rsp_dc));
            chk($sformatf("rnd dc_rsp c%0d", c), dc_rsp_valid, (c == rsp_cyc && rsp_dc));
            if (k_ic) chk($sformatf("rnd ic_data c%0d", c), ic_rsp_data, e_ic);
            if (k_dc) chk($sformatf("rnd dc_data c%0d", c), dc_rsp_data, e_dc);
            if (gi || gd) begin
                line = gd ? dc_addr[6:4] : ic_addr[6:4];
                if (gd && dc_we) begin
                    mm[line] = dc_wdata; known[line] = 1'b1;
                    rsp_val = dc_wdata; rsp_known = 1'b1;
                end else begin
                    rsp_val = mm[line]; rsp_known = known[line];
                end
                rsp_dc = gd; rsp_cyc = c + L; free_at = c + L + 1; m_last_dc = gd;
            end
            @(posedge clk); #1;
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
